// File: rtl/joystick_conditioner.sv
// Multi-channel joystick conditioner: sample-tick debounce, optional autofire on
// masked bits, and a round-robin valid/ready stream of debounced-state change events.
module joystick_conditioner #(
  parameter int unsigned     CHANNELS       = 2,
  parameter int unsigned     WIDTH          = 8,
  parameter int unsigned     SAMPLE_DIV     = 28000,
  parameter int unsigned     STABLE_SAMPLES = 4,
  parameter int unsigned     AUTOFIRE_TICKS = 40,
  parameter logic [WIDTH-1:0] FIRE_MASK     = WIDTH'(8'b0001_0000)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  input  logic [CHANNELS*WIDTH-1:0]                    joy_raw,
  input  logic [CHANNELS-1:0]                          autofire_en,
  output logic [CHANNELS*WIDTH-1:0]                    joy_out,
  output logic                                         evt_valid,
  input  logic                                         evt_ready,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] evt_chan,
  output logic [WIDTH-1:0]                             evt_state
);

  localparam int unsigned N  = CHANNELS * WIDTH;
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned DW = $clog2(SAMPLE_DIV);
  localparam int unsigned AW = (AUTOFIRE_TICKS > 1) ? $clog2(AUTOFIRE_TICKS) : 1;

  logic [DW-1:0]       div_q, div_d;
  logic                tick;
  logic [N-1:0]        eff;
  logic [N-1:0]        deb_q, deb_d;
  logic [3:0]          cnt_q [N];
  logic [3:0]          cnt_d [N];
  logic [AW-1:0]       af_q, af_d;
  logic                phase_q, phase_d;
  logic [N-1:0]        out_q, out_d;
  logic [CHANNELS-1:0] dirty_q, dirty_d, chg, clr;
  logic [CW-1:0]       last_q, last_d, chan_q, chan_d;
  logic                valid_q, valid_d;
  logic [WIDTH-1:0]    state_q, state_d;

  logic                load, found_hi, found_lo;
  int unsigned         last_i, pick_hi, pick_lo, pick_i;

  always_comb begin
    tick  = (div_q == DW'(SAMPLE_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  always_comb begin
    eff   = in_valid ? joy_raw : '1;
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (tick) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (eff[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == 4'(STABLE_SAMPLES - 1)) begin
          deb_d[i] = eff[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    af_d    = af_q;
    phase_d = phase_q;
    if (tick) begin
      if (af_q == AW'(AUTOFIRE_TICKS - 1)) begin
        af_d    = '0;
        phase_d = ~phase_q;
      end else begin
        af_d = af_q + 1'b1;
      end
    end
  end

  // Autofire forces masked bits released (high) during phase 0.
  always_comb begin
    out_d = '1;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned b = 0; b < WIDTH; b++) begin
        out_d[c*WIDTH + b] = deb_q[c*WIDTH + b] | (autofire_en[c] & FIRE_MASK[b] & ~phase_q);
      end
    end
  end

  // Round-robin: search channels above last first, then wrap to 0..last.
  always_comb begin
    load     = !valid_q || evt_ready;
    last_i   = 32'(last_q);
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = 0;
    pick_lo  = 0;
    chg      = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      chg[c] = (deb_d[c*WIDTH +: WIDTH] != deb_q[c*WIDTH +: WIDTH]);
      if (!found_hi && dirty_q[c] && (c > last_i)) begin
        found_hi = 1'b1;
        pick_hi  = c;
      end
      if (!found_lo && dirty_q[c] && (c <= last_i)) begin
        found_lo = 1'b1;
        pick_lo  = c;
      end
    end
    pick_i  = found_hi ? pick_hi : pick_lo;

    valid_d = valid_q;
    chan_d  = chan_q;
    state_d = state_q;
    last_d  = last_q;
    clr     = '0;
    if (load) begin
      if (found_hi || found_lo) begin
        valid_d = 1'b1;
        chan_d  = CW'(pick_i);
        last_d  = CW'(pick_i);
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          if (c == pick_i) begin
            state_d = deb_q[c*WIDTH +: WIDTH];
            clr[c]  = 1'b1;
          end
        end
      end else begin
        valid_d = 1'b0;
      end
    end
    // A change on the same edge as its grant keeps the channel dirty.
    dirty_d = (dirty_q & ~clr) | chg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      deb_q   <= '1;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
      af_q    <= '0;
      phase_q <= 1'b0;
      out_q   <= '1;
      dirty_q <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      state_q <= '1;
      last_q  <= CW'(CHANNELS - 1);
    end else begin
      div_q   <= div_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      af_q    <= af_d;
      phase_q <= phase_d;
      out_q   <= out_d;
      dirty_q <= dirty_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign joy_out   = out_q;
  assign evt_valid = valid_q;
  assign evt_chan  = chan_q;
  assign evt_state = state_q;

endmodule

// File: tb/tb_joystick_conditioner.sv
// Scoreboard bench for joystick_conditioner: stimulus pushes expected events,
// a negedge monitor pops and compares on every accepted event.
module tb_joystick_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] joy_raw;
  logic [1:0]  autofire_en;
  logic [15:0] joy_out;
  logic        evt_valid;
  logic        evt_ready;
  logic [0:0]  evt_chan;
  logic [7:0]  evt_state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [0:0] chan;
    logic [7:0] state;
  } evt_t;

  evt_t exp_q[$];
  evt_t e;

  always #5 clk = ~clk;

  joystick_conditioner #(
    .CHANNELS(2), .WIDTH(8), .SAMPLE_DIV(4), .STABLE_SAMPLES(3),
    .AUTOFIRE_TICKS(2), .FIRE_MASK(8'h10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .joy_raw(joy_raw),
    .autofire_en(autofire_en), .joy_out(joy_out), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_chan(evt_chan), .evt_state(evt_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic evt_t mk(input logic c, input logic [7:0] s);
    mk = {c, s};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int maxc, input logic [15:0] mask,
                          input logic [15:0] val, input string name);
    int n;
    n = 0;
    while (((joy_out & mask) !== val) && (n < maxc)) begin
      cyc(1);
      n++;
    end
    chk(name, 32'(joy_out & mask), 32'(val));
  endtask

  // Monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: actual chan %0d state %h, required none",
                 evt_chan, evt_state);
      end else begin
        e = exp_q.pop_front();
        chk("evt_chan", 32'(evt_chan), 32'(e.chan));
        chk("evt_state", 32'(evt_state), 32'(e.state));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: actual still running, required finished");
    $fatal(1, "timeout");
  end

  int   last_edge, ntog, bad0, bad1;
  logic prev4;

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; joy_raw = 16'h0000;
    autofire_en = 2'b00; evt_ready = 1'b1;

    // Reset state and first debounce
    cyc(3);
    chk("rst_joy_out", 32'(joy_out), 32'hFFFF);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    exp_q.push_back(mk(1'b0, 8'h00));
    exp_q.push_back(mk(1'b1, 8'h00));
    rst_n = 1'b1;
    cyc(11);
    chk("post_rst_11", 32'(joy_out), 32'hFFFF);
    cyc(1);
    chk("post_rst_12", 32'(joy_out), 32'hFFFF);
    cyc(1);
    chk("post_rst_13", 32'(joy_out), 32'h0000);
    chk("first_evt_valid", 32'(evt_valid), 1);
    chk("first_evt_chan", 32'(evt_chan), 0);
    cyc(4);

    // Release everything
    joy_raw = 16'hFFFF;
    exp_q.push_back(mk(1'b0, 8'hFF));
    exp_q.push_back(mk(1'b1, 8'hFF));
    cyc(20);
    chk("release_all", 32'(joy_out), 32'hFFFF);

    // Glitch rejection: two ticks low
    joy_raw = 16'hFFFE;
    cyc(8);
    joy_raw = 16'hFFFF;
    cyc(20);
    chk("glitch", 32'(joy_out), 32'hFFFF);

    // Debounce ch1
    joy_raw = 16'hFEFF;
    exp_q.push_back(mk(1'b1, 8'hFE));
    wait_out(13, 16'hFF00, 16'hFE00, "deb_ch1");
    chk("deb_ch0_steady", 32'(joy_out[7:0]), 32'hFF);
    cyc(10);

    // Backpressure and round robin (last=1 -> ch0 first)
    evt_ready = 1'b0;
    joy_raw = 16'h7F7F;
    exp_q.push_back(mk(1'b0, 8'h7F));
    exp_q.push_back(mk(1'b1, 8'h7F));
    cyc(20);
    chk("bp_valid", 32'(evt_valid), 1);
    chk("bp_chan", 32'(evt_chan), 0);
    chk("bp_state", 32'(evt_state), 32'h7F);
    cyc(5);
    chk("bp_hold_chan", 32'(evt_chan), 0);
    chk("bp_hold_state", 32'(evt_state), 32'h7F);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    chk("bp_next_valid", 32'(evt_valid), 1);
    chk("bp_next_chan", 32'(evt_chan), 1);
    chk("bp_next_state", 32'(evt_state), 32'h7F);
    evt_ready = 1'b1;
    cyc(3);
    joy_raw = 16'h7FFF;
    exp_q.push_back(mk(1'b0, 8'hFF));
    cyc(20);
    // last=0 now: simultaneous change serves ch1 first
    joy_raw = 16'h0000;
    exp_q.push_back(mk(1'b1, 8'h00));
    exp_q.push_back(mk(1'b0, 8'h00));
    cyc(20);

    // Autofire on ch0 only
    joy_raw = 16'hEFEF;
    exp_q.push_back(mk(1'b1, 8'hEF));
    exp_q.push_back(mk(1'b0, 8'hEF));
    cyc(20);
    autofire_en = 2'b01;
    cyc(2);
    prev4 = joy_out[4];
    last_edge = -1; ntog = 0; bad0 = 0; bad1 = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (joy_out[15:8] !== 8'hEF) bad1++;
      if ((joy_out[7:0] | 8'h10) !== 8'hFF) bad0++;
      if (joy_out[4] !== prev4) begin
        if (last_edge >= 0) chk("af_period", 32'(i - last_edge), 8);
        last_edge = i;
        ntog++;
        prev4 = joy_out[4];
      end
    end
    chk("af_toggles", 32'(ntog >= 4), 1);
    chk("af_ch1_steady", 32'(bad1), 0);
    chk("af_ch0_other_bits", 32'(bad0), 0);
    autofire_en = 2'b00;
    cyc(2);
    chk("af_off", 32'(joy_out), 32'hEFEF);

    // in_valid drop with ch0 pressed
    joy_raw = 16'h0000;
    exp_q.push_back(mk(1'b1, 8'h00));
    exp_q.push_back(mk(1'b0, 8'h00));
    cyc(20);
    in_valid = 1'b0;
    exp_q.push_back(mk(1'b1, 8'hFF));
    exp_q.push_back(mk(1'b0, 8'hFF));
    cyc(9);
    chk("drop_not_early", 32'(joy_out[7:0]), 32'h00);
    wait_out(4, 16'h00FF, 16'h00FF, "drop_release_ch0");
    cyc(20);
    chk("drop_all_released", 32'(joy_out), 32'hFFFF);

    // Reset aborts a pending event
    in_valid = 1'b1;
    evt_ready = 1'b0;
    joy_raw = 16'h0000;
    cyc(20);
    chk("pending_before_rst", 32'(evt_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_abort_valid", 32'(evt_valid), 0);
    chk("rst_abort_joy_out", 32'(joy_out), 32'hFFFF);
    exp_q.delete();
    joy_raw = 16'hFFFF;
    cyc(3);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cyc(30);
    chk("after_rst_idle", 32'(joy_out), 32'hFFFF);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
